// File: rtl/ccastles_pkg.sv
// Shared types for the CCastles video RAM arbiter.
// State encoding, owner codes and default bus widths.
package ccastles_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        VID_A = 3'd1,
        VID_D = 3'd2,
        CPU_A = 3'd3,
        CPU_D = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2
    } own_t;

endpackage

// File: rtl/ccastles_vram_starve_guard.sv
// Bounds the run of video slots granted while the CPU waits.
// Built only when VRAM_STARVE_GUARD_EN is defined.
module ccastles_vram_starve_guard #(
    parameter int MAX_VID_RUN = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic arb,
    input  logic cpu_req,
    input  logic vid_go,
    input  logic cpu_go,
    output logic force_cpu
);

    localparam int CW = $clog2(MAX_VID_RUN + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (arb) begin
            if (!cpu_req || cpu_go)
                cnt <= '0;
            else if (vid_go)
                cnt <= cnt + 1'b1;
        end
    end

    assign force_cpu = cpu_req && (cnt == CW'(MAX_VID_RUN));

endmodule

// File: rtl/ccastles_vram_arbiter.sv
// Two-cycle slot arbiter for the bitmap VRAM, video first.
// Optional CPU starvation guard: VRAM_STARVE_GUARD_EN.
module ccastles_vram_arbiter
    import ccastles_pkg::*;
#(
    parameter int AW          = AW_DEF,
    parameter int DW          = DW_DEF,
    parameter int MAX_VID_RUN = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic          vid_rvalid,
    output logic [DW-1:0] vid_rdata,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic [1:0]    owner
);

    state_t state, nxt;
    logic   cpu_rd;
    logic   force_cpu;

`ifdef VRAM_STARVE_GUARD_EN
    logic arb;
    assign arb = (state == IDLE) || (state == VID_D) || (state == CPU_D);

    ccastles_vram_starve_guard #(
        .MAX_VID_RUN (MAX_VID_RUN)
    ) u_guard (
        .clk       (clk),
        .reset_n   (reset_n),
        .arb       (arb),
        .cpu_req   (cpu_req),
        .vid_go    (nxt == VID_A),
        .cpu_go    (nxt == CPU_A),
        .force_cpu (force_cpu)
    );
`else
    assign force_cpu = 1'b0;
`endif

    always_comb begin
        nxt = IDLE;
        unique case (state)
            IDLE, VID_D, CPU_D: begin
                if (force_cpu)    nxt = CPU_A;
                else if (vid_req) nxt = VID_A;
                else if (cpu_req) nxt = CPU_A;
                else              nxt = IDLE;
            end
            VID_A:   nxt = VID_D;
            CPU_A:   nxt = CPU_D;
            default: nxt = IDLE;
        endcase
    end

    // RAM controls are captured on slot entry so the RAM sees clean registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
            cpu_rd    <= 1'b0;
        end else begin
            state  <= nxt;
            ram_we <= 1'b0;
            if (nxt == VID_A) begin
                ram_addr <= vid_addr;
            end
            if (nxt == CPU_A) begin
                ram_addr  <= cpu_addr;
                ram_we    <= cpu_we;
                ram_wdata <= cpu_wdata;
                cpu_rd    <= !cpu_we;
            end
        end
    end

    always_comb begin
        vid_ack    = 1'b0;
        cpu_ack    = 1'b0;
        vid_rvalid = 1'b0;
        cpu_rvalid = 1'b0;
        owner      = OWN_NONE;
        unique case (state)
            VID_A: begin
                vid_ack = 1'b1;
                owner   = OWN_VID;
            end
            VID_D: begin
                vid_rvalid = 1'b1;
                owner      = OWN_VID;
            end
            CPU_A: begin
                cpu_ack = 1'b1;
                owner   = OWN_CPU;
            end
            CPU_D: begin
                cpu_rvalid = cpu_rd;
                owner      = OWN_CPU;
            end
            default: owner = OWN_NONE;
        endcase
    end

    assign vid_rdata = ram_rdata;
    assign cpu_rdata = ram_rdata;

endmodule

// File: tb/tb_ccastles_vram_arbiter.sv
// Self-checking bench for ccastles_vram_arbiter with a slot-level model.
// Follows VRAM_STARVE_GUARD_EN to pick the expected guard behaviour.
module tb_ccastles_vram_arbiter;

    localparam int MAXV = 4;

    logic        clk;
    logic        reset_n;
    logic        vid_req;
    logic [15:0] vid_addr;
    logic        vid_ack;
    logic        vid_rvalid;
    logic [7:0]  vid_rdata;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic        cpu_rvalid;
    logic [7:0]  cpu_rdata;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [1:0]  owner;

    ccastles_vram_arbiter #(
        .AW (16), .DW (8), .MAX_VID_RUN (MAXV)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_ack    (vid_ack),
        .vid_rvalid (vid_rvalid),
        .vid_rdata  (vid_rdata),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .owner      (owner)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory contents default to the low address byte, with one marker byte.
    function automatic logic [7:0] dflt(input logic [15:0] a);
        return (a == 16'h1234) ? 8'hA5 : a[7:0];
    endfunction

    logic [7:0] mem [logic [15:0]];
    logic [7:0] ref_mem [logic [15:0]];

    function automatic logic [7:0] rd_mem(input logic [15:0] a);
        return mem.exists(a) ? mem[a] : dflt(a);
    endfunction

    function automatic logic [7:0] rd_ref(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    always @(posedge clk) begin
        ram_rdata <= rd_mem(ram_addr);
        if (ram_we) mem[ram_addr] = ram_wdata;
    end

    typedef struct {
        int          who;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } txn_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   slot = 0;
    int   run = 0;
    txn_t cur = '{0, 1'b0, 16'h0, 8'h0};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // A slot lasts two cycles; a new grant is decided whenever no
    // address phase is in progress.
    task automatic model_step();
        int w;
        if (slot == 2) begin
            if (cur.who == 2 && cur.we) ref_mem[cur.addr] = cur.data;
            slot = 1;
        end else begin
            w = 0;
            if (!cpu_req) run = 0;
`ifdef VRAM_STARVE_GUARD_EN
            if (cpu_req && run == MAXV) w = 2;
            else
`endif
            if (vid_req) w = 1;
            else if (cpu_req) w = 2;
            if (w == 1) begin
                if (cpu_req) run++;
                cur = '{1, 1'b0, vid_addr, 8'h0};
                slot = 2;
            end else if (w == 2) begin
                run = 0;
                cur = '{2, cpu_we, cpu_addr, cpu_wdata};
                slot = 2;
            end else begin
                cur.who = 0;
                slot = 0;
            end
        end
    endtask

    task automatic model_check();
        logic       e_va, e_ca, e_vv, e_cv, e_we;
        logic [1:0] e_own;
        e_va = 0; e_ca = 0; e_vv = 0; e_cv = 0; e_we = 0;
        e_own = 2'd0;
        if (slot == 2) begin
            e_own = 2'(cur.who);
            e_va  = (cur.who == 1);
            e_ca  = (cur.who == 2);
            e_we  = (cur.who == 2) && cur.we;
        end else if (slot == 1) begin
            e_own = 2'(cur.who);
            e_vv  = (cur.who == 1);
            e_cv  = (cur.who == 2) && !cur.we;
        end
        chk("vid_ack", 32'(vid_ack), 32'(e_va));
        chk("cpu_ack", 32'(cpu_ack), 32'(e_ca));
        chk("vid_rvalid", 32'(vid_rvalid), 32'(e_vv));
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(e_cv));
        chk("owner", 32'(owner), 32'(e_own));
        chk("ram_we", 32'(ram_we), 32'(e_we));
        if (slot == 2) chk("ram_addr", 32'(ram_addr), 32'(cur.addr));
        if (e_we) chk("ram_wdata", 32'(ram_wdata), 32'(cur.data));
        if (e_vv) chk("vid_rdata", 32'(vid_rdata), 32'(rd_ref(cur.addr)));
        if (e_cv) chk("cpu_rdata", 32'(cpu_rdata), 32'(rd_ref(cur.addr)));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        model_check();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"},
            32'({vid_ack, cpu_ack, vid_rvalid, cpu_rvalid, ram_we, owner}),
            32'h0);
        chk({tag, "_addr"}, 32'(ram_addr), 32'h0);
        chk({tag, "_wdata"}, 32'(ram_wdata), 32'h0);
    endtask

    int vcnt, ccnt, t_v, t_c, nrv, t_last;
    logic [7:0] rdv [4];
    int t_rv [4];

    initial begin
        reset_n = 1'b0;
        vid_req = 0; vid_addr = '0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        #1 chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cycle();

        // Single video read.
        vid_req = 1; vid_addr = 16'h1234;
        cycle();
        chk("v1_ack", 32'(vid_ack), 32'h1);
        chk("v1_addr", 32'(ram_addr), 32'h1234);
        chk("v1_own", 32'(owner), 32'h1);
        vid_req = 0;
        cycle();
        chk("v1_rvalid", 32'(vid_rvalid), 32'h1);
        chk("v1_rdata", 32'(vid_rdata), 32'hA5);
        cycle();
        chk("v1_idle_own", 32'(owner), 32'h0);

        // Single CPU write.
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0200; cpu_wdata = 8'h3C;
        cycle();
        chk("w_ack", 32'(cpu_ack), 32'h1);
        chk("w_we", 32'(ram_we), 32'h1);
        chk("w_addr", 32'(ram_addr), 32'h0200);
        chk("w_data", 32'(ram_wdata), 32'h3C);
        cpu_req = 0; cpu_we = 0;
        cycle();
        chk("w_we_d", 32'(ram_we), 32'h0);
        chk("w_no_rv", 32'(cpu_rvalid), 32'h0);
        cycle();

        // Contention: video first, CPU right behind with no gap.
        vid_req = 1; vid_addr = 16'h0010;
        cpu_req = 1; cpu_addr = 16'h0020;
        t_v = -1; t_c = -1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (vid_ack) begin t_v = cyc; vid_req = 0; end
            if (cpu_ack) begin t_c = cyc; cpu_req = 0; end
        end
        chk("cont_gap", 32'(t_c - t_v), 32'd2);

        // Continuous video with a waiting CPU read.
        vid_req = 1; vid_addr = 16'h0300;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0040;
        vcnt = 0; ccnt = 0; t_c = -1;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (vid_ack) begin
                if (ccnt == 0) vcnt++;
                vid_addr = vid_addr + 16'h1;
            end
            if (cpu_ack) begin ccnt++; cpu_req = 0; end
        end
`ifdef VRAM_STARVE_GUARD_EN
        chk("guard_run", 32'(vcnt), 32'(MAXV));
        chk("guard_cpu", 32'(ccnt), 32'd1);
`else
        chk("strict_cpu_starved", 32'(ccnt), 32'd0);
`endif
        vid_req = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (cpu_ack) cpu_req = 0;
        end

        // Asynchronous reset in the middle of a video slot.
        vid_req = 1; vid_addr = 16'h1234;
        cycle();
        chk("rst_pre_ack", 32'(vid_ack), 32'h1);
        #1 reset_n = 1'b0;
        #1 chk_all_zero("rst_mid");
        vid_req = 0;
        slot = 0; run = 0; cur.who = 0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        nrv = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (vid_rvalid) nrv++;
        end
        chk("rst_no_rv", 32'(nrv), 32'h0);
        vid_req = 1;
        cycle();
        chk("rst_fresh_ack", 32'(vid_ack), 32'h1);
        vid_req = 0;
        cycle();
        chk("rst_fresh_data", 32'(vid_rdata), 32'hA5);
        cycle();

        // Back-to-back CPU reads of 0..3.
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0000;
        nrv = 0;
        for (int i = 0; i < 14; i++) begin
            cycle();
            if (cpu_rvalid && nrv < 4) begin
                rdv[nrv] = cpu_rdata; t_rv[nrv] = cyc; nrv++;
            end
            if (cpu_ack) begin
                if (cpu_addr < 16'h3) cpu_addr = cpu_addr + 16'h1;
                else cpu_req = 0;
            end
        end
        chk("b2b_count", 32'(nrv), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < nrv) chk("b2b_data", 32'(rdv[k]), 32'(k));
            if (k > 0 && k < nrv)
                chk("b2b_space", 32'(t_rv[k] - t_rv[k-1]), 32'd2);
        end

        // Random traffic against the slot model.
        t_last = 0;
        for (int i = 0; i < 600; i++) begin
            cycle();
            if (!vid_req || vid_ack) begin
                vid_req  = ($urandom_range(0, 2) == 0);
                vid_addr = 16'h0100 + 16'($urandom_range(0, 15));
            end
            if (!cpu_req || cpu_ack) begin
                cpu_req   = ($urandom_range(0, 1) == 0);
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = 16'h0100 + 16'($urandom_range(0, 15));
                cpu_wdata = 8'($urandom);
            end
        end
        vid_req = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (cpu_ack) cpu_req = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ccastles_vram_arbiter.md
Name: ccastles_vram_arbiter

Overview:
- Time-shares the single-port bitmap video RAM between two requesters: video scan-out fetch and the CPU (read/write).
- Sits between the video address generator, the CPU bus decode and the RAM, inside the CCastles core. Everything runs on clk.
- Video has fixed priority. A run-length guard can force the CPU into a slot.
- Every RAM access is a fixed 2-cycle slot: address phase, then data phase.

Parameters:
- AW, 16, address width of RAM and both requesters
- DW, 8, data width
- MAX_VID_RUN, 4, consecutive video grants allowed while the CPU is pending (used only with the optional feature)

Ports:
- clk  in  1  system clock; all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- vid_req  in  1  video read request, level, held until vid_ack
- vid_addr  in  AW  video read address, stable while vid_req=1
- vid_ack  out  1  1-cycle pulse: video request accepted (address phase)
- vid_rvalid  out  1  1-cycle pulse: vid_rdata valid
- vid_rdata  out  DW  read data, wired from ram_rdata
- cpu_req  in  1  CPU request, level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_ack  out  1  1-cycle pulse: CPU request accepted
- cpu_rvalid  out  1  1-cycle pulse for CPU reads only
- cpu_rdata  out  DW  read data, wired from ram_rdata
- ram_addr  out  AW  RAM address, registered
- ram_we  out  1  RAM write strobe, registered
- ram_wdata  out  DW  RAM write data, registered
- ram_rdata  in  DW  synchronous RAM read data, valid the cycle after the address is presented
- owner  out  2  debug: 0 idle, 1 video, 2 CPU; reflects the current slot

Behaviour:
- Reset (reset_n=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0: ram_addr, ram_we, ram_wdata, ack, rvalid, owner.
  - The guard counter is cleared.
  - Any in-flight access is dropped; no rvalid is issued after reset releases.
- States: IDLE, VID_A, VID_D, CPU_A, CPU_D.
- Arbitration point: the end of IDLE or the end of any *_D cycle.
  - vid_req=1 goes to VID_A.
  - Otherwise cpu_req=1 goes to CPU_A.
  - Otherwise go to IDLE.
  - Back-to-back slots are allowed with no idle cycle in between.
- VID_A:
  - ram_addr = vid_addr (registered at entry), ram_we=0.
  - vid_ack=1, owner=1.
  - Next state: VID_D.
- VID_D:
  - vid_rvalid=1; vid_rdata = ram_rdata is valid this cycle.
  - ram_we=0. Then arbitrate.
- CPU_A:
  - ram_addr = cpu_addr, ram_we = cpu_we, ram_wdata = cpu_wdata (all registered at entry).
  - cpu_ack=1, owner=2.
- CPU_D:
  - cpu_rvalid=1 only if the access was a read; ram_we=0. Then arbitrate.
- Latency: a request sampled at edge N gives ack in cycle N+1 and rvalid in cycle N+2. Peak throughput is one access per 2 cycles.
- Handshake rules:
  - A requester keeps req, addr and data stable until its ack cycle.
  - In the cycle after ack, req/addr is treated as a new request. The requester drops req or presents the next access.
  - The A-cycle value of req is never sampled.
- Simultaneous requests: video wins, unless the guard forces the CPU (see Optional Feature).
- ram_we is high for exactly one cycle per write (the CPU_A cycle) and is never high in a *_D cycle.
- owner returns to 0 only in IDLE.

Optional Feature:
- Macro: VRAM_STARVE_GUARD_EN.
- With the macro defined:
  - A counter (width to hold MAX_VID_RUN) increments on each VID_A entered while cpu_req=1.
  - It clears on CPU_A entry and whenever cpu_req=0 at the arbitration point.
  - When the counter equals MAX_VID_RUN and cpu_req=1, the arbitration point selects CPU_A even if vid_req=1.
- Without the macro: no counter is built and priority is strict video-first. A CPU can starve indefinitely under continuous video requests.

Decomposition:
- Shared package ccastles_pkg holds:
  - state encoding constants (IDLE=0, VID_A, VID_D, CPU_A, CPU_D)
  - owner codes (OWN_NONE=0, OWN_VID=1, OWN_CPU=2)
  - default AW/DW constants
- Optional sub-module ccastles_vram_starve_guard: counter plus force output, instantiated under the macro.
- The FSM and RAM output registers stay in the top module.

Test Plan:
- Video read alone: reset, vid_req=1, vid_addr=16'h1234 held one slot, RAM model returns 8'hA5 → vid_ack in cycle N+1 with ram_addr=16'h1234, ram_we=0; vid_rvalid in N+2 with vid_rdata=8'hA5; owner 1 then 0.
- CPU write: cpu_req=1, cpu_we=1, cpu_addr=16'h0200, cpu_wdata=8'h3C → ram_we=1 for exactly one cycle with that addr/data; cpu_ack in the same cycle; no cpu_rvalid.
- Contention: vid_req and cpu_req rise in the same cycle, video drops after its ack → order VID_A, VID_D, CPU_A, CPU_D with no IDLE gap; cpu_ack 2 cycles after vid_ack.
- Guard: continuous vid_req with cpu_req held, macro on with MAX_VID_RUN=4 → 4 video slots, then CPU_A. Macro off → cpu_ack never asserts in 40 cycles.
- Reset mid-operation: assert reset_n=0 during VID_A → all outputs 0 immediately (asynchronous), no vid_rvalid after release, state IDLE; a fresh request is served normally.
- Back-to-back CPU reads at 16'h0000..16'h0003 with the RAM returning addr[7:0] → 4 cpu_rvalid pulses spaced 2 cycles apart with data 00, 01, 02, 03.
